// File: rtl/nib_ram_ctrl.sv
// Single-port nibble data RAM controller: LD/ST plus internal ADD/NOR read-modify-write,
// with a zeroing sweep after reset. Define NIB_RAM_PARITY_EN to store an even-parity bit per word.
//   state | meaning
//   INIT  | sweeping 0 into every word, ready low
//   IDLE  | accepting READ/WRITE/ADD/NOR requests
//   RMW   | writing back the ADD/NOR result, ready low
module nib_ram_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  carry,
  output logic                  zero,
  output logic                  perr
);

`ifdef NIB_RAM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [1:0] {INIT, IDLE, RMW} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   sweep, sweep_nxt;
  logic [MEM_W-1:0]        mem [0:DEPTH-1];

  logic                    mem_we;
  logic [IDX_W-1:0]        mem_widx;
  logic [MEM_W-1:0]        mem_wword;

  logic                    in_range;
  logic [MEM_W-1:0]        rd_word;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_perr;

  logic [IDX_W-1:0]        rmw_idx;
  logic                    rmw_in_range;
  logic                    rmw_add;
  logic [DATA_WIDTH-1:0]   rmw_tmp;
  logic [DATA_WIDTH-1:0]   rmw_wdata;
  logic                    rmw_perr;
  logic [DATA_WIDTH:0]     rmw_sum;
  logic [DATA_WIDTH-1:0]   rmw_res;
  logic                    rmw_carry;

  function automatic logic [MEM_W-1:0] enc(input logic [DATA_WIDTH-1:0] d);
`ifdef NIB_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign in_range = ({1'b0, addr} < DEPTH_LIM);
  assign rd_word  = mem[addr[IDX_W-1:0]];
  assign rd_data  = in_range ? rd_word[DATA_WIDTH-1:0] : '0;
`ifdef NIB_RAM_PARITY_EN
  // Data and parity together XOR to 0 for a healthy even-parity word.
  assign rd_perr  = in_range && (^rd_word);
`else
  assign rd_perr  = 1'b0;
`endif

  assign rmw_sum   = {1'b0, rmw_tmp} + {1'b0, rmw_wdata};
  assign rmw_res   = rmw_add ? rmw_sum[DATA_WIDTH-1:0] : ~(rmw_tmp | rmw_wdata);
  assign rmw_carry = rmw_add & rmw_sum[DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_widx  = sweep[IDX_W-1:0];
    mem_wword = enc('0);
    case (state)
      INIT: begin
        mem_we = 1'b1;
        if (sweep == LAST) begin
          state_nxt = IDLE;
          sweep_nxt = '0;
        end else begin
          sweep_nxt = sweep + 1'b1;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (op == OP_WRITE) begin
            mem_we    = in_range;
            mem_widx  = addr[IDX_W-1:0];
            mem_wword = enc(wdata);
          end
          if (op[1]) state_nxt = RMW;
        end
      end
      RMW: begin
        mem_we    = rmw_in_range;
        mem_widx  = rmw_idx;
        mem_wword = enc(rmw_res);
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Storage has no reset; the INIT sweep clears it, and reset forces INIT so a pending RMW write is lost.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wword;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid       <= 1'b0;
      rdata        <= '0;
      carry        <= 1'b0;
      zero         <= 1'b0;
      perr         <= 1'b0;
      rmw_idx      <= '0;
      rmw_in_range <= 1'b0;
      rmw_add      <= 1'b0;
      rmw_tmp      <= '0;
      rmw_wdata    <= '0;
      rmw_perr     <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (state == IDLE && req) begin
        if (op == OP_READ) begin
          rvalid <= 1'b1;
          rdata  <= rd_data;
          carry  <= 1'b0;
          zero   <= (rd_data == '0);
          perr   <= rd_perr;
        end else if (op[1]) begin
          rmw_idx      <= addr[IDX_W-1:0];
          rmw_in_range <= in_range;
          rmw_add      <= ~op[0];
          rmw_tmp      <= rd_data;
          rmw_wdata    <= wdata;
          rmw_perr     <= rd_perr;
        end
      end else if (state == RMW) begin
        rvalid <= 1'b1;
        rdata  <= rmw_res;
        carry  <= rmw_carry;
        zero   <= (rmw_res == '0);
        perr   <= rmw_perr;
      end
    end
  end

endmodule

// File: tb/tb_nib_ram_ctrl.sv
// Randomized self-checking bench for nib_ram_ctrl (16 words behind a 5-bit address so
// out-of-range accesses are exercised); reference is a plain integer array.
module tb_nib_ram_ctrl;
  localparam int DW  = 4;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, rvalid, carry, zero, perr;
  logic [DW-1:0] rdata;

  int total = 0;
  int bad = 0;
  int model_mem [DEP];
  bit model_bad_par [DEP];

  nib_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .carry(carry), .zero(zero), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_read(input int a);
    return (a < DEP) ? model_mem[a] : 0;
  endfunction

  // Releases reset at a falling edge, then steps through the sweep while pulsing junk requests.
  task automatic reset_seq();
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {carry, zero, perr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEP; i++) begin model_mem[i] = 0; model_bad_par[i] = 0; end
    for (int k = 1; k <= DEP; k++) begin
      req   = $urandom_range(0, 1);
      op    = 2'($urandom_range(0, 3));
      addr  = AW'($urandom_range(0, DEP - 1));
      wdata = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("init_ready", ready, (k >= DEP) ? 1 : 0);
      chk("init_rvalid", rvalid, 0);
    end
    req = 1'b0;
  endtask

  // Issue one request at a falling edge (ready is high) and check its response.
  task automatic do_op(input logic [1:0] o, input int a, input int d);
    int m, res, cy, pe;
    m  = model_read(a);
    pe = (a < DEP) ? int'(model_bad_par[a]) : 0;
    req = 1'b1; op = o; addr = AW'(a); wdata = DW'(d);
    chk("acc_ready", ready, 1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    case (o)
      2'b00: begin
        chk("rd_rvalid", rvalid, 1);
        chk("rd_data", rdata, m);
        chk("rd_flags", {carry, zero}, {1'b0, m == 0});
        chk("rd_perr", perr, pe);
      end
      2'b01: begin
        chk("wr_rvalid", rvalid, 0);
        if (a < DEP) begin model_mem[a] = d; model_bad_par[a] = 0; end
      end
      default: begin
        if (o == 2'b10) begin
          res = (m + d) % 16;
          cy  = (m + d) / 16;
        end else begin
          res = (~(m | d)) & 15;
          cy  = 0;
        end
        chk("rmw_ready_low", ready, 0);
        chk("rmw_rvalid_early", rvalid, 0);
        // A request during the busy cycle must be dropped.
        req = 1'b1; op = 2'b01; addr = AW'($urandom_range(0, DEP - 1)); wdata = DW'($urandom);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        chk("rmw_rvalid", rvalid, 1);
        chk("rmw_data", rdata, res);
        chk("rmw_carry", carry, cy);
        chk("rmw_zero", zero, res == 0);
        chk("rmw_perr", perr, pe);
        chk("rmw_ready_back", ready, 1);
        if (a < DEP) begin model_mem[a] = res; model_bad_par[a] = 0; end
      end
    endcase
  endtask

  initial begin
    reset_seq();

    do_op(2'b00, 5, 0);
    do_op(2'b01, 3, 4'hA);
    do_op(2'b00, 3, 0);
    do_op(2'b01, 7, 4'h9);
    do_op(2'b10, 7, 4'h8);
    do_op(2'b00, 7, 0);
    do_op(2'b01, 2, 4'h5);
    do_op(2'b11, 2, 4'hA);
    do_op(2'b00, 2, 0);
    do_op(2'b01, 20, 4'hF);
    do_op(2'b00, 20, 0);
    do_op(2'b10, 25, 4'h3);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        @(negedge clk);
        chk("idle_rvalid", rvalid, 0);
      end
      do_op(2'($urandom_range(0, 3)), $urandom_range(0, 2 * DEP - 1), $urandom_range(0, 15));
    end

    // Reset lands in the RMW cycle of an ADD: write-back must be lost and the sweep redone.
    do_op(2'b01, 7, 4'h3);
    req = 1'b1; op = 2'b10; addr = AW'(7); wdata = DW'(4'h4);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("mid_rmw_ready", ready, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rmw_rvalid", rvalid, 0);
    reset_seq();
    do_op(2'b00, 7, 0);

    // Reset part-way through the sweep restarts it from zero.
    do_op(2'b01, 12, 4'h6);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge clk);
    reset_seq();
    do_op(2'b00, 12, 0);

`ifdef NIB_RAM_PARITY_EN
    do_op(2'b01, 9, 4'h6);
    dut.mem[9][DW] = ~dut.mem[9][DW];
    model_bad_par[9] = 1;
    do_op(2'b00, 9, 0);
    do_op(2'b10, 9, 4'h1);
    do_op(2'b00, 9, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nib_ram_ctrl.md
# nib_ram_ctrl

Parametrised single-port data RAM controller for the nibble CPU. It replaces the tristate data bus with separate write and read buses and a req/ready/rvalid handshake. It executes LD and ST directly, and performs the read-modify-write for ADDM and NORM internally, returning the result flags CMPM/ADDM need. After reset it clears its own memory.

## Interface
- DATA_WIDTH, 4, word width in bits
- ADDR_WIDTH, 12, address width in bits
- DEPTH, 1<<ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  1  request strobe; sampled only when ready=1
- op  input  2  00 READ, 01 WRITE, 10 ADD (mem+wdata), 11 NOR (~(mem|wdata))
- addr  input  ADDR_WIDTH  word address
- wdata  input  DATA_WIDTH  write data / RMW operand
- ready  output  1  controller accepts a request this cycle
- rvalid  output  1  one-cycle pulse: rdata/carry/zero/perr valid
- rdata  output  DATA_WIDTH  read data or RMW result
- carry  output  1  ADD carry-out; 0 for other ops
- zero  output  1  rdata == 0, registered with rdata
- perr  output  1  parity error on the word read; valid with rvalid

## Operation
- States: INIT, IDLE, RMW.
- INIT (entered on reset):
  - Sweep counter runs 0..DEPTH-1 and writes 0 to one word per cycle (parity bit 0 with the macro).
  - ready=0 throughout; moves to IDLE after writing DEPTH-1.
- IDLE: ready=1. Accept at edge E0 when req=1:
  - READ: rdata<=mem[addr] at E0; rvalid=1 for the cycle after E0; carry=0.
  - WRITE: mem[addr]<=wdata at E0; no rvalid; stays IDLE.
  - ADD/NOR: at E0 latch addr, wdata and op, read mem[addr] into a temp register, go to RMW.
- RMW: ready=0.
  - At E1, compute the result, write it to the latched addr, load rdata/carry/zero, pulse rvalid for the cycle after E1, return to IDLE.
- ADD arithmetic: (DATA_WIDTH+1)-bit sum of the two unsigned operands. rdata takes the low DATA_WIDTH bits; carry takes bit DATA_WIDTH.
- NOR: carry=0.
- Addresses ≥ DEPTH: writes are dropped; reads return 0; perr=0.
- req while ready=0 is ignored and not queued; the requester must hold it or re-issue.
- Reset mid-RMW: the pending write is discarded, the target word keeps its old value, and the sweep restarts.
- Reset mid-INIT: the sweep restarts from 0.

## Timing
- Reset values: ready 0, rvalid 0, rdata 0, carry 0, zero 0, perr 0; state INIT; sweep counter 0.
- First ready=1 exactly DEPTH cycles after rst_n deasserts.
- READ latency: 1 cycle (rvalid in the cycle after the accept edge). Back-to-back READs sustain 1 per cycle.
- WRITE then READ of the same addr on consecutive edges returns the new data.
- ADD/NOR latency: 2 cycles. ready is low for exactly 1 cycle. Peak throughput is 1 RMW per 2 cycles.
- rvalid never asserts in INIT and never lasts more than one cycle per request.
- All outputs are registered. There is no combinational path from inputs to outputs except ready, which depends only on state.

## Configuration
- NIB_RAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit, generated on every WRITE, RMW write and INIT write.
  - On READ and on the RMW read, perr=1 with rvalid if the stored parity mismatches.
  - An RMW with bad parity still writes its result with fresh parity.
- NIB_RAM_PARITY_EN undefined:
  - The memory is DATA_WIDTH wide.
  - perr is tied to 0.

## Test plan
- Reset release with DEPTH=16 -> ready=0 for 16 cycles, then 1; READ of addr 5 returns 0 and zero=1.
- WRITE addr 3 = 4'hA, then READ addr 3 on the next edge -> rvalid one cycle later, rdata=4'hA, zero=0, carry=0.
- mem[7]=4'h9, ADD addr 7 wdata 4'h8 -> ready low 1 cycle; rvalid 2 cycles after accept; rdata=4'h1, carry=1; later READ 7 returns 4'h1.
- mem[2]=4'h5, NOR addr 2 wdata 4'hA -> rdata=4'h0, zero=1, carry=0; mem[2]=0.
- Assert rst_n=0 in the cycle after an ADD is accepted on addr 7 (holding 4'h3) -> no rvalid, full sweep repeats, mem[7]=0 afterwards; req asserted during INIT is ignored.
- With NIB_RAM_PARITY_EN: backdoor-flip the parity bit of addr 9, READ 9 -> perr=1 with rvalid; a subsequent ADD on 9 then READ 9 -> perr=0.
